// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcodes, ALU selects and state encoding for the processor control unit
package proc_pkg;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    // Unassigned opcodes fall through to NOOP.
    function automatic state_t op_to_state(input logic [3:0] op);
        case (op)
            OP_STORE: return ST_STORE;
            OP_LOAD:  return ST_LOAD_A;
            OP_ADD:   return ST_ADD;
            OP_SUB:   return ST_SUB;
            OP_HALT:  return ST_HALT;
            default:  return ST_NOOP;
        endcase
    endfunction

endpackage

// File: rtl/proc_pc.sv
// rtl/proc_pc.sv - program counter with increment enable and natural modulo-2^PC_W wrap
module proc_pc #(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc_en,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (inc_en) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/proc_controller.sv
// rtl/proc_controller.sv - fetch/decode/execute sequencer driving the datapath control inputs
module proc_controller
    import proc_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] im_addr,
    input  logic [15:0]     im_data,
    output logic [7:0]      D_Addr,
    output logic            D_wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_en,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic [2:0]      Alu_s0,
    output logic            halted,
    output logic [3:0]      state_o,
    output logic [15:0]     ir_o
);

    state_t          state;
    logic [15:0]     ir;
    logic [PC_W-1:0] pc;

    // PC advances only while the fetched word is being captured into IR.
    proc_pc #(.PC_W(PC_W)) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (state == ST_DECODE),
        .pc     (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            ir    <= '0;
        end else begin
            case (state)
                ST_INIT:   state <= ST_FETCH;
                ST_FETCH:  state <= ST_DECODE;
                ST_DECODE: begin
                    ir    <= im_data;
                    state <= op_to_state(im_data[15:12]);
                end
                ST_LOAD_A: state <= ST_LOAD_B;
                ST_NOOP,
                ST_LOAD_B,
                ST_STORE,
                ST_ADD,
                ST_SUB:    state <= ST_FETCH;
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_INIT;
            endcase
        end
    end

    // Decoded purely from registered state and IR, so reset kills enables without waiting for a clock.
    always_comb begin
        D_Addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        Alu_s0     = '0;
        halted     = 1'b0;
        case (state)
            ST_STORE: begin
                D_Addr     = ir[11:4];
                RF_Ra_addr = ir[3:0];
                D_wr       = 1'b1;
            end
            ST_LOAD_A: begin
                D_Addr = ir[11:4];
                RF_s   = 1'b1;
            end
            ST_LOAD_B: begin
                D_Addr    = ir[11:4];
                RF_s      = 1'b1;
                RF_W_addr = ir[3:0];
                RF_W_en   = 1'b1;
            end
            ST_ADD: begin
                RF_Ra_addr = ir[11:8];
                RF_Rb_addr = ir[7:4];
                RF_W_addr  = ir[3:0];
                RF_W_en    = 1'b1;
                Alu_s0     = ALU_ADD;
            end
            ST_SUB: begin
                RF_Ra_addr = ir[11:8];
                RF_Rb_addr = ir[7:4];
                RF_W_addr  = ir[3:0];
                RF_W_en    = 1'b1;
                Alu_s0     = ALU_SUB;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign im_addr = pc;
    assign state_o = state;
    assign ir_o    = ir;

endmodule

// File: tb/tb_proc_controller.sv
// tb/tb_proc_controller.sv - instruction-level trace model checked cycle by cycle against proc_controller
module tb_proc_controller;
    import proc_pkg::*;

    typedef struct packed {
        logic [6:0]  im_addr;
        logic [7:0]  d_addr;
        logic        d_wr;
        logic        rf_s;
        logic [3:0]  w_addr;
        logic        w_en;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
        logic        halted;
        logic [3:0]  state;
        logic [15:0] ir;
    } cyc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mrom [0:127];

    logic        rst_n;
    logic [6:0]  im_addr;
    logic [15:0] im_data;
    logic [7:0]  D_Addr;
    logic        D_wr, RF_s, RF_W_en, halted;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state_o;
    logic [2:0]  Alu_s0;
    logic [15:0] ir_o;

    logic        rst_b_n;
    logic [2:0]  im_addr_b;
    logic [15:0] im_data_b;
    logic [7:0]  D_Addr_b;
    logic        D_wr_b, RF_s_b, RF_W_en_b, halted_b;
    logic [3:0]  RF_W_addr_b, RF_Ra_addr_b, RF_Rb_addr_b, state_o_b;
    logic [2:0]  Alu_s0_b;
    logic [15:0] ir_o_b;

    proc_controller dut (
        .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_data(im_data),
        .D_Addr(D_Addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_addr(RF_W_addr),
        .RF_W_en(RF_W_en), .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
        .Alu_s0(Alu_s0), .halted(halted), .state_o(state_o), .ir_o(ir_o)
    );

    proc_controller #(.PC_W(3)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .im_addr(im_addr_b), .im_data(im_data_b),
        .D_Addr(D_Addr_b), .D_wr(D_wr_b), .RF_s(RF_s_b), .RF_W_addr(RF_W_addr_b),
        .RF_W_en(RF_W_en_b), .RF_Ra_addr(RF_Ra_addr_b), .RF_Rb_addr(RF_Rb_addr_b),
        .Alu_s0(Alu_s0_b), .halted(halted_b), .state_o(state_o_b), .ir_o(ir_o_b)
    );

    // Synchronous instruction ROMs: data appears the cycle after the address.
    always @(posedge clk) begin
        im_data   <= mrom[im_addr];
        im_data_b <= mrom[{4'b0000, im_addr_b}];
    end

    int   tests = 0;
    int   fails = 0;
    cyc_t exp_q[$];

    function automatic cyc_t mk(input state_t s, input int a, input logic [15:0] ir);
        cyc_t c;
        c         = '0;
        c.state   = s;
        c.im_addr = a[6:0];
        c.ir      = ir;
        return c;
    endfunction

    function automatic cyc_t sample(input bit sel);
        cyc_t c;
        if (!sel) begin
            c = {im_addr, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr,
                 RF_Rb_addr, Alu_s0, halted, state_o, ir_o};
        end else begin
            c = {4'b0000, im_addr_b, D_Addr_b, D_wr_b, RF_s_b, RF_W_addr_b, RF_W_en_b,
                 RF_Ra_addr_b, RF_Rb_addr_b, Alu_s0_b, halted_b, state_o_b, ir_o_b};
        end
        return c;
    endfunction

    // Expand the program in mrom, instruction by instruction, into the per-cycle outputs it implies.
    task automatic build_trace(input int n, input int pc_w);
        int          pc;
        int          mask;
        logic [15:0] ir;
        logic [15:0] ins;
        cyc_t        c;
        pc   = 0;
        mask = (1 << pc_w) - 1;
        ir   = '0;
        exp_q.delete();
        exp_q.push_back(mk(ST_INIT, 0, ir));
        while (exp_q.size() < n) begin
            exp_q.push_back(mk(ST_FETCH, pc, ir));
            exp_q.push_back(mk(ST_DECODE, pc, ir));
            ins = mrom[pc];
            ir  = ins;
            pc  = (pc + 1) & mask;
            case (ins[15:12])
                OP_STORE: begin
                    c = mk(ST_STORE, pc, ir);
                    c.d_addr = ins[11:4];
                    c.ra     = ins[3:0];
                    c.d_wr   = 1'b1;
                    exp_q.push_back(c);
                end
                OP_LOAD: begin
                    c = mk(ST_LOAD_A, pc, ir);
                    c.d_addr = ins[11:4];
                    c.rf_s   = 1'b1;
                    exp_q.push_back(c);
                    c.state  = ST_LOAD_B;
                    c.w_addr = ins[3:0];
                    c.w_en   = 1'b1;
                    exp_q.push_back(c);
                end
                OP_ADD, OP_SUB: begin
                    c = mk((ins[15:12] == OP_ADD) ? ST_ADD : ST_SUB, pc, ir);
                    c.ra     = ins[11:8];
                    c.rb     = ins[7:4];
                    c.w_addr = ins[3:0];
                    c.w_en   = 1'b1;
                    c.alu    = (ins[15:12] == OP_ADD) ? 3'b001 : 3'b010;
                    exp_q.push_back(c);
                end
                OP_HALT: begin
                    c = mk(ST_HALT, pc, ir);
                    c.halted = 1'b1;
                    while (exp_q.size() < n) exp_q.push_back(c);
                end
                default: exp_q.push_back(mk(ST_NOOP, pc, ir));
            endcase
        end
    endtask

    task automatic hold_reset(input bit sel);
        @(negedge clk);
        if (sel) rst_b_n = 1'b0; else rst_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset(input bit sel);
        if (sel) rst_b_n = 1'b1; else rst_n = 1'b1;
    endtask

    task automatic run_trace(input bit sel, input int n, input string name);
        cyc_t act;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            act = sample(sel);
            tests++;
            if (act !== exp_q[i]) begin
                fails++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, act, exp_q[i]);
            end
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) mrom[i] = 16'h0000;
    endtask

    task automatic test_reset();
        clear_rom();
        hold_reset(0);
        tests++;
        if (state_o !== ST_INIT || ir_o !== 16'h0 || im_addr !== 7'd0 || D_wr !== 1'b0 || RF_W_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: state=%0d ir=%h pc=%0d d_wr=%b w_en=%b expected state=%0d ir=0 pc=0 d_wr=0 w_en=0",
                     state_o, ir_o, im_addr, D_wr, RF_W_en, ST_INIT);
        end
        build_trace(40, 7);
        release_reset(0);
        run_trace(0, 40, "idle_noop");
    endtask

    task automatic test_add_sub();
        clear_rom();
        mrom[0] = 16'h3123;
        mrom[1] = 16'h4456;
        hold_reset(0);
        build_trace(20, 7);
        release_reset(0);
        run_trace(0, 20, "add_sub");
    endtask

    task automatic test_load_store();
        clear_rom();
        mrom[0] = 16'h21B7;
        mrom[1] = 16'h1FF2;
        mrom[2] = 16'h2000;
        hold_reset(0);
        build_trace(24, 7);
        release_reset(0);
        run_trace(0, 24, "load_store");
    endtask

    task automatic test_halt();
        clear_rom();
        mrom[2] = 16'h5000;
        hold_reset(0);
        build_trace(40, 7);
        release_reset(0);
        run_trace(0, 40, "halt");
    endtask

    task automatic test_mid_reset();
        clear_rom();
        mrom[0] = 16'h21B7;
        hold_reset(0);
        build_trace(5, 7);
        release_reset(0);
        run_trace(0, 5, "mid_reset_pre");
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (RF_W_en !== 1'b0 || state_o !== ST_INIT || im_addr !== 7'd0 || ir_o !== 16'h0) begin
            fails++;
            $display("FAIL mid_reset_async: w_en=%b state=%0d pc=%0d ir=%h expected w_en=0 state=%0d pc=0 ir=0",
                     RF_W_en, state_o, im_addr, ir_o, ST_INIT);
        end
        @(negedge clk);
        build_trace(12, 7);
        release_reset(0);
        run_trace(0, 12, "mid_reset_restart");
    endtask

    task automatic test_wrap_illegal();
        clear_rom();
        mrom[5] = 16'hF0A5;
        hold_reset(1);
        build_trace(45, 3);
        release_reset(1);
        run_trace(1, 45, "wrap_illegal");
        hold_reset(1);
    endtask

    task automatic test_random();
        int op;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 128; i++) begin
                op = int'($urandom_range(0, 15));
                if (op == 5 && $urandom_range(0, 9) != 0) op = 3;
                mrom[i] = {op[3:0], 12'($urandom())};
            end
            hold_reset(0);
            build_trace(200, 7);
            release_reset(0);
            run_trace(0, 200, "random");
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rst_b_n = 1'b0;
        clear_rom();
        test_reset();
        test_add_sub();
        test_load_store();
        test_halt();
        test_mid_reset();
        test_wrap_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
